// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer for one external bidirectional shift register.
//
// A command (dir, len, clr) is taken over a valid/ready handshake. If clr is set, the register is
// first flushed with WIDTH zero-shifts. Then cmd_len bits are shifted in from ser_in. Shifting
// runs at one bit per DIV clocks. The settled parallel word is then returned over a valid/ready
// response channel.
//
// Ports
//   clk, rstn              clock; synchronous active-low reset, shared with the shift register
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only in idle
//   cmd_dir                0: shift toward MSB (d enters bit0), 1: toward LSB (d enters MSB)
//   cmd_len                bits to shift, clamped to WIDTH
//   cmd_clr                flush with WIDTH zeros before the data bits
//   ser_in/ser_strobe      serial data in; strobe marks the cycles where ser_in is consumed
//   sr_en/sr_dir/sr_d      drive to the shift register
//   sr_q                   parallel output of the shift register
//   rsp_valid/rsp_ready    response handshake
//   rsp_data               parallel result (sr_q while the response is presented, else 0)
//   rsp_parity             XOR of the data bits shifted in (only if SHIFT_SEQ_CTRL_PARITY_EN)
//
// Configuration: define SHIFT_SEQ_CTRL_PARITY_EN to add the rsp_parity output.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1,
  localparam int unsigned LW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LW-1:0]    cmd_len,
  input  logic             cmd_clr,
  input  logic             ser_in,
  output logic             ser_strobe,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  ,
  output logic             rsp_parity
`endif
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {StIdle, StClear, StShift, StResp} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic            dir_q, dir_d;
  logic [LW-1:0]   len_clamped;
  logic            tick;

  assign len_clamped = (cmd_len > LW'(WIDTH)) ? LW'(WIDTH) : cmd_len;
  assign tick        = (presc_q == PW'(DIV - 1));

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic parity_q, parity_d;
  assign rsp_parity = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      presc_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    dir_d      = dir_q;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    parity_d   = parity_q;
`endif
    cmd_ready  = 1'b0;
    ser_strobe = 1'b0;
    sr_en      = 1'b0;
    sr_dir     = 1'b0;
    sr_d       = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          len_d   = len_clamped;
          presc_d = '0;
          cnt_d   = '0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          parity_d = 1'b0;
`endif
          // An empty data phase collapses so the response follows one cycle after acceptance.
          if (cmd_clr) begin
            state_d = StClear;
          end else if (len_clamped == '0) begin
            state_d = StResp;
          end else begin
            state_d = StShift;
          end
        end
      end

      StClear: begin
        sr_en   = tick;
        sr_dir  = dir_q;
        sr_d    = 1'b0;
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (cnt_q == LW'(WIDTH - 1)) begin
            cnt_d   = '0;
            presc_d = '0;
            state_d = (len_q == '0) ? StResp : StShift;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end

      StShift: begin
        sr_en      = tick;
        ser_strobe = tick;
        sr_dir     = dir_q;
        sr_d       = ser_in;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          parity_d = parity_q ^ ser_in;
`endif
          if (cnt_q == len_q - LW'(1)) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end

      StResp: begin
        rsp_valid = 1'b1;
        rsp_data  = sr_q;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (DIV=1 and DIV=4) each driving a modelled shift
// register. Commands are checked cycle by cycle against timing and data derived arithmetically.
module tb_shift_seq_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned LW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          valid1, valid4;
  logic          cmd_dir, cmd_clr, ser_in, rsp_ready;
  logic [LW-1:0] cmd_len;
  logic          ready1, strobe1, en1, dir1, d1, rv1;
  logic          ready4, strobe4, en4, dir4, d4, rv4;
  logic [W-1:0]  rd1, rd4, q1, q4;
  logic          par1, par4;

  int sel;
  int n_vec = 0;
  int n_err = 0;
  int mw[2];

  logic         o_ready, o_strobe, o_en, o_dir, o_d, o_rv, o_par;
  logic [W-1:0] o_rd;
  assign o_ready  = (sel != 0) ? ready4  : ready1;
  assign o_strobe = (sel != 0) ? strobe4 : strobe1;
  assign o_en     = (sel != 0) ? en4     : en1;
  assign o_dir    = (sel != 0) ? dir4    : dir1;
  assign o_d      = (sel != 0) ? d4      : d1;
  assign o_rv     = (sel != 0) ? rv4     : rv1;
  assign o_rd     = (sel != 0) ? rd4     : rd1;
  assign o_par    = (sel != 0) ? par4    : par1;

`ifndef SHIFT_SEQ_CTRL_PARITY_EN
  assign par1 = 1'b0;
  assign par4 = 1'b0;
`endif

  // External shift registers sharing the sequencer reset.
  always_ff @(posedge clk) begin
    if (!rstn) q1 <= '0;
    else if (en1) q1 <= dir1 ? {d1, q1[W-1:1]} : {q1[W-2:0], d1};
  end
  always_ff @(posedge clk) begin
    if (!rstn) q4 <= '0;
    else if (en4) q4 <= dir4 ? {d4, q4[W-1:1]} : {q4[W-2:0], d4};
  end

  shift_seq_ctrl #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_dir(cmd_dir),
    .cmd_len(cmd_len), .cmd_clr(cmd_clr), .ser_in(ser_in), .ser_strobe(strobe1), .sr_en(en1),
    .sr_dir(dir1), .sr_d(d1), .sr_q(q1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1)
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    , .rsp_parity(par1)
`endif
  );

  shift_seq_ctrl #(.WIDTH(W), .DIV(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .cmd_valid(valid4), .cmd_ready(ready4), .cmd_dir(cmd_dir),
    .cmd_len(cmd_len), .cmd_clr(cmd_clr), .ser_in(ser_in), .ser_strobe(strobe4), .sr_en(en4),
    .sr_dir(dir4), .sr_d(d4), .sr_q(q4), .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_data(rd4)
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    , .rsp_parity(par4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full command: accept, per-cycle checks of the shift phase, response with optional stall.
  task automatic run_cmd(input int s, input bit dir, input int len_raw, input bit clr,
                         input int hold, input bit use_pat, input logic [7:0] pat,
                         output int data, output int pulses);
    int div, len, nclr, lat, w, par, j;
    bit en_e, st_e;
    sel    = s;
    div    = (s != 0) ? 4 : 1;
    len    = (len_raw > W) ? W : len_raw;
    nclr   = clr ? W : 0;
    lat    = (nclr + len) * div + 1;
    w      = clr ? 0 : mw[s];
    par    = 0;
    j      = 0;
    pulses = 0;

    @(negedge clk);
    cmd_dir   = dir;
    cmd_len   = LW'(len_raw);
    cmd_clr   = clr;
    rsp_ready = 1'($urandom);
    if (s != 0) valid4 = 1'b1;
    else valid1 = 1'b1;
    #1;
    check_eq("idle_ready", o_ready, 1);
    check_eq("idle_rsp_valid", o_rv, 0);
    check_eq("idle_sr_en", o_en, 0);
    @(posedge clk);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      valid1    = 1'b0;
      valid4    = 1'b0;
      cmd_len   = LW'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_clr   = 1'($urandom);
      rsp_ready = (k < lat) ? 1'($urandom) : 1'b0;
      en_e      = (k % div == 0) && (k < lat);
      st_e      = en_e && (k > nclr * div);
      ser_in    = (st_e && use_pat) ? pat[7-j] : 1'($urandom);
      #1;
      check_eq("sr_en", o_en, en_e);
      check_eq("ser_strobe", o_strobe, st_e);
      check_eq("rsp_valid", o_rv, (k == lat));
      check_eq("busy_ready", o_ready, 0);
      if (o_en) pulses++;
      if (en_e) begin
        check_eq("sr_dir", o_dir, dir);
        check_eq("sr_d", o_d, st_e ? ser_in : 1'b0);
      end
      if (st_e) begin
        if (dir) w = (w >> 1) | (int'(ser_in) << (W - 1));
        else w = ((w << 1) | int'(ser_in)) & ((1 << W) - 1);
        par = par ^ int'(ser_in);
        j++;
      end
    end

    check_eq("rsp_data", o_rd, w);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    check_eq("rsp_parity", o_par, par);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check_eq("hold_valid", o_rv, 1);
      check_eq("hold_data", o_rd, w);
      check_eq("hold_ready", o_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    mw[s] = w;
    data  = w;
  endtask

  // Reset asserted during the third data bit must abandon the command.
  task automatic abort_cmd();
    sel = 0;
    @(negedge clk);
    cmd_dir   = 1'($urandom);
    cmd_len   = LW'(8);
    cmd_clr   = 1'b0;
    rsp_ready = 1'b0;
    valid1    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      valid1 = 1'b0;
      ser_in = 1'($urandom);
      #1;
      check_eq("abort_sr_en", o_en, 1);
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ser_in = 1'b1;
    #1;
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_sr_en", o_en, 0);
    check_eq("rst_strobe", o_strobe, 0);
    check_eq("rst_sr_dir", o_dir, 0);
    check_eq("rst_sr_d", o_d, 0);
    check_eq("rst_rsp_valid", o_rv, 0);
    check_eq("rst_rsp_data", o_rd, 0);
    rstn = 1'b1;
    mw[0] = 0;
    mw[1] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_valid", o_rv, 0);
      check_eq("post_rst_ready", o_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p;
    sel       = 0;
    rstn      = 1'b0;
    valid1    = 1'b0;
    valid4    = 1'b0;
    cmd_dir   = 1'b0;
    cmd_len   = '0;
    cmd_clr   = 1'b0;
    ser_in    = 1'b0;
    rsp_ready = 1'b0;
    mw[0]     = 0;
    mw[1]     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_ready", o_ready, 1);
    check_eq("reset_sr_en", o_en, 0);
    check_eq("reset_strobe", o_strobe, 0);
    check_eq("reset_sr_dir", o_dir, 0);
    check_eq("reset_rsp_valid", o_rv, 0);
    check_eq("reset_rsp_data", o_rd, 0);
    rstn = 1'b1;

    run_cmd(0, 1'b1, 8, 1'b1, 0, 1'b1, 8'hB2, d, p);
    check_eq("t2_data", d, 8'h4D);
    check_eq("t2_pulses", p, 16);
    run_cmd(0, 1'b0, 8, 1'b1, 0, 1'b1, 8'hB2, d, p);
    check_eq("t1_data", d, 8'hB2);
    check_eq("t1_pulses", p, 16);
    run_cmd(0, 1'b0, 4, 1'b0, 0, 1'b1, 8'hF0, d, p);
    check_eq("t3_data", d, 8'h2F);
    check_eq("t3_pulses", p, 4);
    run_cmd(0, 1'($urandom), 0, 1'b0, 0, 1'b0, 8'h00, d, p);
    check_eq("t4_len0_pulses", p, 0);
    check_eq("t4_len0_data", d, 8'h2F);
    run_cmd(0, 1'b0, 15, 1'b0, 1, 1'b0, 8'h00, d, p);
    check_eq("t4_len15_pulses", p, 8);
    run_cmd(1, 1'b0, 3, 1'b0, 0, 1'b1, 8'hA0, d, p);
    check_eq("t5_div4_pulses", p, 3);
    check_eq("t5_div4_data", d, 8'h05);
    run_cmd(0, 1'b1, 5, 1'b0, 5, 1'b0, 8'h00, d, p);
    check_eq("t6_pulses", p, 5);
    abort_cmd();

    for (int i = 0; i < 150; i++) begin
      run_cmd(($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom), int'($urandom_range(0, 15)),
              1'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00, d, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
